// File: rtl/trace_pkg.sv
// Shared types and helpers for the writeback trace buffer.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRIG  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic WRAP_DROP      = 1'b0;
    localparam logic WRAP_OVERWRITE = 1'b1;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace store, first-word-fall-through read, write latency 1.
// When full, a push without a pop either overwrites the oldest entry or is dropped; both set ovf_o.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      wrap_i,
    input  logic                      push_i,
    input  logic [W-1:0]              push_dat_i,
    input  logic                      pop_i,
    output logic                      rd_vld_o,
    output logic [W-1:0]              rd_dat_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic                      ovf_o
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          wr_en;

    logic empty, full, pop_ok;
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign pop_ok = pop_i && !empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        if (push_i && full && !pop_ok) begin
            ovf_d = 1'b1;
            if (wrap_i == WRAP_OVERWRITE) begin
                // Overwrite oldest: head and tail advance together, occupancy unchanged.
                wr_en  = 1'b1;
                tail_d = tail_q + 1'b1;
                head_d = head_q + 1'b1;
            end
        end else begin
            if (push_i) begin
                wr_en  = 1'b1;
                tail_d = tail_q + 1'b1;
            end
            if (pop_ok) begin
                head_d = head_q + 1'b1;
            end
            if (push_i && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (!push_i && pop_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i && !clr_i) begin
            mem_q[tail_q] <= push_dat_i;
        end
    end

    assign rd_vld_o = !empty;
    assign rd_dat_o = empty ? '0 : mem_q[head_q];
    assign count_o  = count_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback display pair plus armed/triggered trace capture into a FWFT FIFO.
// Display and capture update one cycle after a retire; the reader pops at will.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int DEPTH     = 16,
    parameter int WRAP      = 1,
    parameter int POST_TRIG = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      RetValid,
    input  logic [PC_W-1:0]           RetPC,
    input  logic [DATA_W-1:0]         RetData,
    input  logic                      RetIsBranch,
    input  logic                      RetIsJal,
    input  logic                      Arm,
    input  logic                      Clear,
    input  logic                      TrigEn,
    input  logic [PC_W-1:0]           TrigPC,
    input  logic                      RdEn,
    output logic                      RdValid,
    output logic [PC_W-1:0]           RdPC,
    output logic [DATA_W-1:0]         RdData,
    output logic [cnt_w(DEPTH)-1:0]   Count,
    output logic                      Overflow,
    output logic                      Done,
    output logic [PC_W-1:0]           PCDisplay,
    output logic [DATA_W-1:0]         WriteDataDisplay
);
    localparam int CW = cnt_w(DEPTH);
    localparam int EW = PC_W + DATA_W;

    state_e             state_q, state_d;
    logic [CW-1:0]      post_q, post_d;
    logic [PC_W-1:0]    pc_disp_q;
    logic [DATA_W-1:0]  dat_disp_q;
    logic [DATA_W-1:0]  eff_dat;
    logic               hit;
    logic               push;
    logic [EW-1:0]      rd_dat;

    assign eff_dat = (RetIsBranch && !RetIsJal) ? '0 : RetData;
    assign hit     = RetValid && TrigEn && (RetPC == TrigPC);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            post_q  <= post_d;
        end
    end

    // post_q counts entries still to be captured after the current one.
    always_comb begin
        state_d = state_q;
        post_d  = post_q;
        if (Clear) begin
            state_d = IDLE;
            post_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (Arm) state_d = ARMED;
                ARMED: begin
                    if (hit) begin
                        post_d  = CW'(POST_TRIG - 1);
                        state_d = (POST_TRIG == 1) ? DONE : TRIG;
                    end
                end
                TRIG: begin
                    if (RetValid) begin
                        post_d = post_q - 1'b1;
                        if (post_q <= CW'(1)) state_d = DONE;
                    end
                end
                DONE: if (Arm) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        push = RetValid && !Clear && ((state_q == ARMED) || (state_q == TRIG));
        Done = (state_q == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_disp_q  <= '0;
            dat_disp_q <= '0;
        end else if (RetValid) begin
            pc_disp_q  <= RetPC;
            dat_disp_q <= eff_dat;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .clr_i      (Clear),
        .wrap_i     ((WRAP != 0) ? WRAP_OVERWRITE : WRAP_DROP),
        .push_i     (push),
        .push_dat_i ({RetPC, eff_dat}),
        .pop_i      (RdEn),
        .rd_vld_o   (RdValid),
        .rd_dat_o   (rd_dat),
        .count_o    (Count),
        .ovf_o      (Overflow)
    );

    assign RdPC             = rd_dat[EW-1:DATA_W];
    assign RdData           = rd_dat[DATA_W-1:0];
    assign PCDisplay        = pc_disp_q;
    assign WriteDataDisplay = dat_disp_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench: three instances (DEPTH 8 main, DEPTH 4 overwrite, DEPTH 4 drop) share one stimulus.
module tb_wb_trace_buffer;
    logic        Clk = 1'b0;
    logic        Reset, RetValid, RetIsBranch, RetIsJal, Arm, Clear, TrigEn, RdEn;
    logic [31:0] RetPC, RetData, TrigPC;

    logic        a_vld, a_ovf, a_done;
    logic [31:0] a_pc, a_dat, a_pcd, a_wdd;
    logic [3:0]  a_cnt;
    logic        w1_vld, w1_ovf, w1_done;
    logic [31:0] w1_pc, w1_dat, w1_pcd, w1_wdd;
    logic [2:0]  w1_cnt;
    logic        w0_vld, w0_ovf, w0_done;
    logic [31:0] w0_pc, w0_dat, w0_pcd, w0_wdd;
    logic [2:0]  w0_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    wb_trace_buffer #(.DEPTH(8), .WRAP(1), .POST_TRIG(3)) dut_a (
        .Clk(Clk), .Reset(Reset), .RetValid(RetValid), .RetPC(RetPC), .RetData(RetData),
        .RetIsBranch(RetIsBranch), .RetIsJal(RetIsJal), .Arm(Arm), .Clear(Clear),
        .TrigEn(TrigEn), .TrigPC(TrigPC), .RdEn(RdEn), .RdValid(a_vld), .RdPC(a_pc),
        .RdData(a_dat), .Count(a_cnt), .Overflow(a_ovf), .Done(a_done),
        .PCDisplay(a_pcd), .WriteDataDisplay(a_wdd));

    wb_trace_buffer #(.DEPTH(4), .WRAP(1), .POST_TRIG(3)) dut_w1 (
        .Clk(Clk), .Reset(Reset), .RetValid(RetValid), .RetPC(RetPC), .RetData(RetData),
        .RetIsBranch(RetIsBranch), .RetIsJal(RetIsJal), .Arm(Arm), .Clear(Clear),
        .TrigEn(TrigEn), .TrigPC(TrigPC), .RdEn(RdEn), .RdValid(w1_vld), .RdPC(w1_pc),
        .RdData(w1_dat), .Count(w1_cnt), .Overflow(w1_ovf), .Done(w1_done),
        .PCDisplay(w1_pcd), .WriteDataDisplay(w1_wdd));

    wb_trace_buffer #(.DEPTH(4), .WRAP(0), .POST_TRIG(1)) dut_w0 (
        .Clk(Clk), .Reset(Reset), .RetValid(RetValid), .RetPC(RetPC), .RetData(RetData),
        .RetIsBranch(RetIsBranch), .RetIsJal(RetIsJal), .Arm(Arm), .Clear(Clear),
        .TrigEn(TrigEn), .TrigPC(TrigPC), .RdEn(RdEn), .RdValid(w0_vld), .RdPC(w0_pc),
        .RdData(w0_dat), .Count(w0_cnt), .Overflow(w0_ovf), .Done(w0_done),
        .PCDisplay(w0_pcd), .WriteDataDisplay(w0_wdd));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] d,
                          input logic br, input logic jal);
        RetValid = 1'b1; RetPC = pc; RetData = d; RetIsBranch = br; RetIsJal = jal;
        tick();
        RetValid = 1'b0; RetIsBranch = 1'b0; RetIsJal = 1'b0;
    endtask

    task automatic pulse_arm();
        Arm = 1'b1; tick(); Arm = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear = 1'b1; tick(); Clear = 1'b0;
    endtask

    task automatic pop();
        RdEn = 1'b1; tick(); RdEn = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; RetValid = 0; RetIsBranch = 0; RetIsJal = 0; Arm = 0; Clear = 0;
        TrigEn = 0; RdEn = 0; RetPC = '0; RetData = '0; TrigPC = '0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_cnt", a_cnt, 0);
        chk("rst_vld", a_vld, 0);
        chk("rst_rd", {a_pc, a_dat}, 0);
        chk("rst_flags", {a_ovf, a_done}, 0);
        chk("rst_disp", {a_pcd, a_wdd}, 0);

        // Idle: retire updates display but is not captured
        retire(32'hC, 32'h9, 0, 0);
        chk("idle_disp", {a_pcd, a_wdd}, {32'hC, 32'h9});
        chk("idle_nocap", a_cnt, 0);

        // Basic capture and FWFT drain
        pulse_arm();
        retire(32'h0, 32'd5, 0, 0);
        retire(32'h4, 32'd6, 0, 0);
        retire(32'h8, 32'd7, 0, 0);
        chk("basic_cnt", a_cnt, 3);
        chk("basic_e0", {a_pc, a_dat}, {32'h0, 32'd5}); pop();
        chk("basic_e1", {a_pc, a_dat}, {32'h4, 32'd6}); pop();
        chk("basic_e2", {a_pc, a_dat}, {32'h8, 32'd7}); pop();
        chk("basic_empty", {a_vld, a_pc, a_dat}, 0);
        pop();
        chk("pop_empty_ignored", a_cnt, 0);

        // Branch data zeroing, jal keeps data
        retire(32'h10, 32'h55, 1, 0);
        chk("br_disp", {a_pcd, a_wdd}, {32'h10, 32'h0});
        chk("br_rec", {a_pc, a_dat}, {32'h10, 32'h0});
        retire(32'h14, 32'h14, 1, 1);
        chk("jal_disp", a_wdd, 32'h14);
        pop();
        chk("jal_rec", {a_pc, a_dat}, {32'h14, 32'h14});
        pop();

        // Full-FIFO policies on the DEPTH=4 instances
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < 6; i++) retire(32'(4 * i), 32'(i + 'h100), 0, 0);
        chk("w1_cnt", w1_cnt, 4);
        chk("w1_ovf", w1_ovf, 1);
        chk("w1_head", w1_pc, 32'h8);
        chk("w0_cnt", w0_cnt, 4);
        chk("w0_ovf", w0_ovf, 1);
        chk("w0_head", w0_pc, 32'h0);
        chk("a_nowrap", {a_cnt, a_ovf}, {4'd6, 1'b0});
        pop(); pop(); pop();
        chk("w0_tail", w0_pc, 32'hC);
        chk("w1_tail", {w1_pc, w1_dat}, {32'h14, 32'h105});

        // Full with simultaneous push and pop
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < 8; i++) retire(32'h40 + 32'(4 * i), 32'(i), 0, 0);
        chk("full_cnt", a_cnt, 8);
        chk("full_head", {a_pc, a_dat}, {32'h40, 32'd0});
        RdEn = 1'b1;
        retire(32'h60, 32'h99, 0, 0);
        RdEn = 1'b0;
        chk("pp_cnt", a_cnt, 8);
        chk("pp_ovf", a_ovf, 0);
        chk("pp_head", {a_pc, a_dat}, {32'h44, 32'd1});
        for (int i = 0; i < 7; i++) pop();
        chk("pp_tail", {a_pc, a_dat}, {32'h60, 32'h99});
        pop();

        // Empty with simultaneous push and pop
        RdEn = 1'b1;
        retire(32'h70, 32'h1, 0, 0);
        RdEn = 1'b0;
        chk("ep_cnt", a_cnt, 1);

        // Trigger with post-trigger window
        pulse_clear();
        pulse_arm();
        TrigEn = 1'b1; TrigPC = 32'h20;
        retire(32'h18, 32'h18, 0, 0);
        retire(32'h1C, 32'h1C, 0, 0);
        retire(32'h20, 32'h20, 0, 0);
        chk("w0_done_pt1", {w0_done, w0_cnt}, {1'b1, 3'd3});
        retire(32'h24, 32'h24, 0, 0);
        chk("trig_notdone", a_done, 0);
        retire(32'h28, 32'h28, 0, 0);
        chk("trig_done", a_done, 1);
        retire(32'h2C, 32'h2C, 0, 0);
        chk("trig_cnt", a_cnt, 5);
        chk("trig_disp", a_pcd, 32'h2C);
        for (int i = 0; i < 5; i++) begin
            chk("trig_entry", a_pc, 32'h18 + 32'(4 * i));
            pop();
        end
        pulse_arm();
        chk("rearm_done_clr", a_done, 0);

        // Clear together with a retire, then reset mid-capture
        pulse_clear();
        pulse_arm();
        TrigPC = 32'h80;
        retire(32'h70, 32'h1, 0, 0);
        retire(32'h74, 32'h2, 0, 0);
        Clear = 1'b1;
        retire(32'h78, 32'h33, 0, 0);
        Clear = 1'b0;
        chk("clr_cnt", {a_cnt, a_vld, a_ovf, a_done}, 0);
        chk("clr_disp", {a_pcd, a_wdd}, {32'h78, 32'h33});
        retire(32'h7C, 32'h4, 0, 0);
        chk("clr_idle", a_cnt, 0);
        pulse_arm();
        retire(32'h80, 32'h5, 0, 0);
        retire(32'h84, 32'h6, 0, 0);
        chk("pre_rst_cnt", a_cnt, 2);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("rst2_all", {a_cnt, a_vld, a_ovf, a_done, a_pc, a_dat, a_pcd, a_wdd}, 0);
        retire(32'h88, 32'h7, 0, 0);
        chk("rst2_idle", a_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
